// File: rtl/gpu_pkg.sv
// gpu_pkg: frame sequencer state encoding and default swap timing
package gpu_pkg;
  typedef enum logic [1:0] {WaitBuffer, Launch, Render, Done} frame_state_t;
  localparam int DEFAULT_PERIOD_CYCLES = 2_000_000;
  localparam int DEFAULT_MIN_PERIOD = 500_000;
endpackage

// File: rtl/swap_timer.sv
// swap_timer: free-running swap timer deciding fixed-period or adaptive framebuffer swaps
module swap_timer
  import gpu_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
  parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD,
  parameter int TIMER_WIDTH = 22
) (
  input  logic gpu_clk,
  input  logic rst,
  input  logic adaptive,
  input  logic done_state,
  output logic swap
);
  logic [TIMER_WIDTH-1:0] timer;
  logic mode;
  always_comb swap = (timer == TIMER_WIDTH'(PERIOD_CYCLES - 1)) ||
                     (mode && done_state && timer >= TIMER_WIDTH'(MIN_PERIOD - 1));
  // mode only changes at a swap so one period never mixes fixed and adaptive rules
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      timer <= '0;
      mode <= adaptive;
    end else begin
      timer <= swap ? '0 : timer + 1'b1;
      mode <= swap ? adaptive : mode;
    end
  end
endmodule

// File: rtl/frame_controller.sv
// frame_controller: per-frame GPU sequencer driving fetch reset, matrix start and buffer swap/clear
module frame_controller
  import gpu_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
  parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD,
  parameter int TIMER_WIDTH = 22,
  parameter int COUNT_WIDTH = 16,
  parameter int CLEAR_GUARD = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   adaptive_in,
  input  logic                   pause_in,
  input  logic                   buffer_ready_in,
  input  logic                   pixel_valid_in,
  input  logic                   done_in,
  output logic                   fetch_rst_out,
  output logic                   matrix_valid_out,
  output logic                   switch_out,
  output logic                   clear_out,
  output logic                   busy_out,
  output logic [COUNT_WIDTH-1:0] pixel_count_out,
  output logic [COUNT_WIDTH-1:0] frame_count_out,
  output logic [COUNT_WIDTH-1:0] dropped_count_out
);
  localparam int GW = $clog2(CLEAR_GUARD + 2);
  frame_state_t state, state_n;
  logic [GW-1:0] guard;
  logic [COUNT_WIDTH-1:0] live, live_n;
  logic swap, launch, frame_done, frame_drop;

  swap_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .MIN_PERIOD(MIN_PERIOD),
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_swap_timer (
    .gpu_clk(clk_in),
    .rst(rst_in),
    .adaptive(adaptive_in),
    .done_state(state == Done),
    .swap(swap)
  );

  // a swap overrides every transition; done_in on the swap cycle still counts as completed
  always_comb begin
    launch = state == WaitBuffer && guard == '0 && buffer_ready_in && !pause_in;
    live_n = (pixel_valid_in && live != '1) ? live + 1'b1 : live;
    frame_done = state == Render && done_in;
    frame_drop = state == Render && swap && !done_in;
    state_n = swap ? WaitBuffer
            : launch ? Launch
            : state == Launch ? Render
            : frame_done ? Done
            : state;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= WaitBuffer;
      guard <= GW'(CLEAR_GUARD);
      live <= '0;
      pixel_count_out <= '0;
      frame_count_out <= '0;
      dropped_count_out <= '0;
      fetch_rst_out <= 1'b1;
      clear_out <= 1'b1;
      switch_out <= 1'b0;
      matrix_valid_out <= 1'b0;
      busy_out <= 1'b0;
    end else begin
      state <= state_n;
      guard <= swap ? GW'(CLEAR_GUARD) : (state == WaitBuffer && guard != '0) ? guard - 1'b1 : guard;
      live <= state == Launch ? '0 : state == Render ? live_n : live;
      pixel_count_out <= (frame_done || frame_drop) ? live_n : pixel_count_out;
      frame_count_out <= frame_done ? frame_count_out + 1'b1 : frame_count_out;
      dropped_count_out <= frame_drop ? dropped_count_out + 1'b1 : dropped_count_out;
      fetch_rst_out <= state_n != Render;
      clear_out <= swap;
      switch_out <= swap;
      matrix_valid_out <= state_n == Launch;
      busy_out <= state_n == Launch || state_n == Render;
    end
  end
endmodule

// File: tb/tb_frame_controller.sv
// tb_frame_controller: scoreboard bench for swap cadence, adaptive swaps, drops, guard, pause and reset
module tb_frame_controller;
  localparam int PERIOD = 100;
  localparam int MINP = 30;
  localparam int CW = 16;
  localparam int GUARD = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic adaptive_in = 1'b0;
  logic pause_in = 1'b0;
  logic buffer_ready_in = 1'b1;
  logic pixel_valid_in = 1'b0;
  logic done_in = 1'b0;
  logic fetch_rst_out, matrix_valid_out, switch_out, clear_out, busy_out;
  logic [CW-1:0] pixel_count_out, frame_count_out, dropped_count_out;

  int cyc = 0;
  int n_matrix = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int ps = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  int q_cyc[$];
  int q_val[$];

  frame_controller #(
    .PERIOD_CYCLES(PERIOD),
    .MIN_PERIOD(MINP),
    .TIMER_WIDTH(22),
    .COUNT_WIDTH(CW),
    .CLEAR_GUARD(GUARD)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .adaptive_in(adaptive_in),
    .pause_in(pause_in),
    .buffer_ready_in(buffer_ready_in),
    .pixel_valid_in(pixel_valid_in),
    .done_in(done_in),
    .fetch_rst_out(fetch_rst_out),
    .matrix_valid_out(matrix_valid_out),
    .switch_out(switch_out),
    .clear_out(clear_out),
    .busy_out(busy_out),
    .pixel_count_out(pixel_count_out),
    .frame_count_out(frame_count_out),
    .dropped_count_out(dropped_count_out)
  );

  always #5 clk_in = ~clk_in;

  // cyc = edges since the last reset edge; timer is 0 in the cycle a switch pulse is visible
  always @(posedge clk_in) begin
    cyc <= rst_in ? 0 : cyc + 1;
    n_matrix <= n_matrix + ((matrix_valid_out === 1'b1) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_switch(output int at);
    at = -1;
    for (int i = 0; i < 3 * PERIOD && at < 0; i++) if (switch_out === 1'b1) at = cyc; else tick();
  endtask

  task automatic wait_matrix(output int at);
    at = -1;
    for (int i = 0; i < 3 * PERIOD && at < 0; i++) if (matrix_valid_out === 1'b1) at = cyc; else tick();
  endtask

  task automatic run_frame(input int launch_at, input int rc, input int npix, input bit pix_on_done, input int extra);
    int m, e;
    q_cyc.push_back(ps + launch_at);
    wait_matrix(m);
    e = q_cyc.pop_front();
    n_cmp++; if (m !== e) begin n_bad++; $display("FAIL matrix_cycle: got %0d want %0d", m, e); end
    n_cmp++; if ({busy_out, fetch_rst_out} !== 2'b11) begin n_bad++; $display("FAIL launch_flags: got %b want 11", {busy_out, fetch_rst_out}); end
    tick();
    n_cmp++; if ({busy_out, fetch_rst_out} !== 2'b10) begin n_bad++; $display("FAIL render_flags: got %b want 10", {busy_out, fetch_rst_out}); end
    for (int i = 0; i < rc; i++) begin
      pixel_valid_in = i < npix - int'(pix_on_done);
      tick();
    end
    pixel_valid_in = pix_on_done;
    done_in = 1'b1;
    exp_frames++;
    q_val.push_back(npix);
    q_val.push_back(exp_frames);
    tick();
    done_in = 1'b0;
    pixel_valid_in = 1'b0;
    e = q_val.pop_front();
    n_cmp++; if (pixel_count_out !== CW'(e)) begin n_bad++; $display("FAIL done_pixels: got %0d want %0d", pixel_count_out, e); end
    e = q_val.pop_front();
    n_cmp++; if (frame_count_out !== CW'(e)) begin n_bad++; $display("FAIL done_frames: got %0d want %0d", frame_count_out, e); end
    n_cmp++; if (fetch_rst_out !== 1'b1) begin n_bad++; $display("FAIL done_fetch_rst: got %b want 1", fetch_rst_out); end
    if (extra > 0) begin
      q_val.push_back(npix);
      for (int i = 0; i < extra; i++) begin pixel_valid_in = 1'b1; tick(); end
      pixel_valid_in = 1'b0;
      e = q_val.pop_front();
      n_cmp++; if (pixel_count_out !== CW'(e)) begin n_bad++; $display("FAIL pixels_in_done: got %0d want %0d", pixel_count_out, e); end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    n_cmp++; if ({fetch_rst_out, matrix_valid_out, switch_out, clear_out, busy_out} !== 5'b10010) begin n_bad++; $display("FAIL reset_flags: got %b want 10010", {fetch_rst_out, matrix_valid_out, switch_out, clear_out, busy_out}); end
    n_cmp++; if (pixel_count_out !== '0) begin n_bad++; $display("FAIL reset_pixels: got %0d want 0", pixel_count_out); end
    n_cmp++; if (frame_count_out !== '0) begin n_bad++; $display("FAIL reset_frames: got %0d want 0", frame_count_out); end
    n_cmp++; if (dropped_count_out !== '0) begin n_bad++; $display("FAIL reset_dropped: got %0d want 0", dropped_count_out); end
    rst_in = 1'b0;
    ps = 0;
    exp_frames = 0;
    exp_drops = 0;
  endtask

  task automatic test_fixed();
    int at, e, nm;
    adaptive_in = 1'b0;
    nm = n_matrix;
    for (int f = 0; f < 3; f++) begin
      run_frame(GUARD + 1, 20, f == 1 ? 7 : f == 2 ? 4 : 0, f == 2, f == 1 ? 3 : 0);
      q_cyc.push_back(ps + PERIOD);
      wait_switch(at);
      e = q_cyc.pop_front();
      n_cmp++; if (at !== e) begin n_bad++; $display("FAIL fixed_swap: got %0d want %0d", at, e); end
      n_cmp++; if (clear_out !== 1'b1) begin n_bad++; $display("FAIL fixed_clear: got %b want 1", clear_out); end
      n_cmp++; if (n_matrix - nm !== 1) begin n_bad++; $display("FAIL matrix_per_frame: got %0d want 1", n_matrix - nm); end
      n_cmp++; if (frame_count_out !== CW'(exp_frames)) begin n_bad++; $display("FAIL frames_after_swap: got %0d want %0d", frame_count_out, exp_frames); end
      nm = n_matrix;
      ps = e;
      tick();
      n_cmp++; if ({switch_out, clear_out} !== 2'b00) begin n_bad++; $display("FAIL pulse_width: got %b want 00", {switch_out, clear_out}); end
    end
  endtask

  task automatic test_adaptive();
    int done_t[4] = '{26, 10, 50, 99};
    int swap_t[4] = '{99, 29, 51, 99};
    int at, e;
    adaptive_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_frame(GUARD + 1, done_t[k] - GUARD - 2, 2, 1'b0, 0);
      q_cyc.push_back(ps + swap_t[k] + 1);
      wait_switch(at);
      e = q_cyc.pop_front();
      n_cmp++; if (at !== e) begin n_bad++; $display("FAIL adaptive_swap_%0d: got %0d want %0d", k, at, e); end
      n_cmp++; if (dropped_count_out !== CW'(exp_drops)) begin n_bad++; $display("FAIL adaptive_dropped_%0d: got %0d want %0d", k, dropped_count_out, exp_drops); end
      ps = e;
      tick();
    end
    adaptive_in = 1'b0;
  endtask

  task automatic test_drop();
    int at, e, m;
    q_cyc.push_back(ps + GUARD + 1);
    wait_matrix(m);
    e = q_cyc.pop_front();
    n_cmp++; if (m !== e) begin n_bad++; $display("FAIL drop_matrix: got %0d want %0d", m, e); end
    tick();
    for (int i = 0; i < 5; i++) begin pixel_valid_in = 1'b1; tick(); end
    pixel_valid_in = 1'b0;
    q_cyc.push_back(ps + PERIOD);
    wait_switch(at);
    e = q_cyc.pop_front();
    exp_drops++;
    n_cmp++; if (at !== e) begin n_bad++; $display("FAIL drop_swap: got %0d want %0d", at, e); end
    n_cmp++; if (dropped_count_out !== CW'(exp_drops)) begin n_bad++; $display("FAIL drop_count: got %0d want %0d", dropped_count_out, exp_drops); end
    n_cmp++; if (frame_count_out !== CW'(exp_frames)) begin n_bad++; $display("FAIL drop_frames: got %0d want %0d", frame_count_out, exp_frames); end
    n_cmp++; if (pixel_count_out !== CW'(5)) begin n_bad++; $display("FAIL drop_pixels: got %0d want 5", pixel_count_out); end
    n_cmp++; if (fetch_rst_out !== 1'b1) begin n_bad++; $display("FAIL drop_fetch_rst: got %b want 1", fetch_rst_out); end
    ps = e;
    tick();
  endtask

  task automatic test_reset_mid();
    int e, m;
    q_cyc.push_back(ps + GUARD + 1);
    wait_matrix(m);
    e = q_cyc.pop_front();
    n_cmp++; if (m !== e) begin n_bad++; $display("FAIL mid_matrix: got %0d want %0d", m, e); end
    tick();
    for (int i = 0; i < 5; i++) begin pixel_valid_in = 1'b1; tick(); end
    pixel_valid_in = 1'b0;
    rst_in = 1'b1;
    tick();
    n_cmp++; if ({fetch_rst_out, matrix_valid_out, switch_out, clear_out, busy_out} !== 5'b10010) begin n_bad++; $display("FAIL mid_reset_flags: got %b want 10010", {fetch_rst_out, matrix_valid_out, switch_out, clear_out, busy_out}); end
    n_cmp++; if ({pixel_count_out, frame_count_out, dropped_count_out} !== '0) begin n_bad++; $display("FAIL mid_reset_counts: got %0d/%0d/%0d want 0/0/0", pixel_count_out, frame_count_out, dropped_count_out); end
    tick();
    n_cmp++; if (clear_out !== 1'b1) begin n_bad++; $display("FAIL mid_reset_clear: got %b want 1", clear_out); end
    rst_in = 1'b0;
    ps = 0;
    exp_frames = 0;
    exp_drops = 0;
    run_frame(GUARD + 1, 20, 3, 1'b0, 0);
  endtask

  task automatic test_guard_pause();
    int at, e, nm;
    q_cyc.push_back(ps + PERIOD);
    wait_switch(at);
    e = q_cyc.pop_front();
    n_cmp++; if (at !== e) begin n_bad++; $display("FAIL guard_swap: got %0d want %0d", at, e); end
    ps = e;
    tick();
    buffer_ready_in = 1'b0;
    while (cyc < ps + 30) tick();
    buffer_ready_in = 1'b1;
    run_frame(31, 20, 1, 1'b0, 0);
    q_cyc.push_back(ps + PERIOD);
    wait_switch(at);
    e = q_cyc.pop_front();
    n_cmp++; if (at !== e) begin n_bad++; $display("FAIL ready_swap: got %0d want %0d", at, e); end
    ps = e;
    tick();
    pause_in = 1'b1;
    nm = n_matrix;
    for (int k = 0; k < 2; k++) begin
      q_cyc.push_back(ps + PERIOD);
      wait_switch(at);
      e = q_cyc.pop_front();
      n_cmp++; if (at !== e) begin n_bad++; $display("FAIL paused_swap_%0d: got %0d want %0d", k, at, e); end
      n_cmp++; if (clear_out !== 1'b1) begin n_bad++; $display("FAIL paused_clear_%0d: got %b want 1", k, clear_out); end
      ps = e;
      tick();
    end
    n_cmp++; if (n_matrix !== nm) begin n_bad++; $display("FAIL paused_launch: got %0d want %0d", n_matrix, nm); end
    n_cmp++; if ({busy_out, fetch_rst_out} !== 2'b01) begin n_bad++; $display("FAIL paused_flags: got %b want 01", {busy_out, fetch_rst_out}); end
    pause_in = 1'b0;
    run_frame(GUARD + 1, 20, 2, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_adaptive();
    test_drop();
    test_reset_mid();
    test_guard_pause();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/frame_controller.md
Name: frame_controller

Overview:
- Parametrised frame sequencer for the GPU pipeline, running on gpu_clk.
- Generates the framebuffer swap/clear pulses and the camera-matrix load pulse, and gates vertex fetch per frame.
- Adds two behaviours over the fixed-timer scheme: an adaptive swap mode that presents a frame as soon as rendering finishes, and a dropped-frame count for frames aborted by a swap timeout.
- Counts pixels per frame and frames presented; sits between the framebuffer ready/valid signals and the fetch/matrix_gen reset inputs.

Parameters:
- PERIOD_CYCLES, 2_000_000, fixed swap period (mode 0) and timeout period (mode 1).
- MIN_PERIOD, 500_000, minimum cycles between swaps in adaptive mode.
- TIMER_WIDTH, 22, swap timer width; must hold PERIOD_CYCLES-1.
- COUNT_WIDTH, 16, width of the pixel, frame and dropped counters.
- CLEAR_GUARD, 4, cycles after a swap during which buffer_ready_in is ignored.

Ports:
- clk_in  in  1  gpu clock
- rst_in  in  1  synchronous active-high reset
- adaptive_in  in  1  0 = fixed period, 1 = adaptive; sampled only at swap
- pause_in  in  1  blocks launch of a new frame
- buffer_ready_in  in  1  framebuffer clear done, ready for pixels
- pixel_valid_in  in  1  fragment shader pixel strobe
- done_in  in  1  pipeline drained for the current frame
- fetch_rst_out  out  1  hold vertex fetch in reset
- matrix_valid_out  out  1  one-cycle pulse to start matrix generation
- switch_out  out  1  one-cycle framebuffer swap pulse
- clear_out  out  1  one-cycle framebuffer clear pulse
- busy_out  out  1  high in Launch/Render
- pixel_count_out  out  COUNT_WIDTH  pixels written in the last finished or aborted frame
- frame_count_out  out  COUNT_WIDTH  completed frames
- dropped_count_out  out  COUNT_WIDTH  frames aborted by a swap

Behaviour:
- Reset state:
  - state = WaitBuffer, guard counter = CLEAR_GUARD, timer = 0, all counters = 0.
  - fetch_rst_out = 1, clear_out = 1, switch_out = 0, matrix_valid_out = 0, busy_out = 0.
  - All outputs are registered.
- WaitBuffer:
  - Guard counter decrements to 0; buffer_ready_in is ignored while it is non-zero.
  - Guard = 0 and buffer_ready_in = 1 and pause_in = 0 -> Launch.
  - fetch_rst_out = 1 throughout.
- Launch: lasts exactly 1 cycle; matrix_valid_out = 1; fetch_rst_out = 1; next state is Render.
- Render:
  - fetch_rst_out = 0; live pixel counter increments on each pixel_valid_in and saturates at all-ones.
  - done_in -> Done: pixel_count_out <= live count (including a pixel arriving that cycle); frame_count_out + 1 (wraps); fetch_rst_out <= 1.
- Done: waits for a swap; pixel_valid_in is ignored.
- Swap timer:
  - Increments every cycle outside reset.
  - Mode 0: swap when timer == PERIOD_CYCLES-1.
  - Mode 1: swap when timer == PERIOD_CYCLES-1, or when (state == Done and timer >= MIN_PERIOD-1).
  - On swap: timer <= 0; switch_out and clear_out pulse for 1 cycle; state <= WaitBuffer; guard reloads to CLEAR_GUARD.
- Swap while in Render:
  - Frame aborted: dropped_count_out + 1 (wraps); pixel_count_out <= live count; fetch_rst_out <= 1.
  - frame_count_out is unchanged.
- Swap while in WaitBuffer or Launch: no count changes; guard reloads. Launch's matrix pulse has already occurred, so a re-launch will pulse again.
- Simultaneous done_in and swap in Render: treated as completed, not dropped. frame_count_out + 1 and the swap proceeds. In adaptive mode this is only possible via the timeout condition.
- pause_in has no effect on the timer; swaps continue while paused, so the framebuffer keeps being cleared.
- Reset mid-frame: returns immediately to the reset state; no count updates.

Decomposition:
- gpu_pkg holds:
  - frame_state_t enum {WaitBuffer, Launch, Render, Done};
  - default PERIOD_CYCLES and MIN_PERIOD constants.
- Sub-module swap_timer (parameters PERIOD_CYCLES, MIN_PERIOD, TIMER_WIDTH):
  - inputs: adaptive, done_state;
  - outputs: the swap pulse;
  - the FSM and counters stay in frame_controller.

Test Plan:
- PERIOD_CYCLES=100, mode 0, buffer_ready_in tied high, done_in after 20 cycles of Render -> switch_out/clear_out every 100 cycles; one matrix pulse per frame; frame_count_out increments once per swap.
- 7 pixel_valid_in pulses in Render, then done_in -> pixel_count_out = 7 at Done; further pixels in Done leave it at 7.
- Mode 1, MIN_PERIOD=30, PERIOD_CYCLES=100, done_in at timer 10 -> swap at timer 29; done_in at timer 50 -> swap at timer 51.
- done_in never asserted, PERIOD_CYCLES=100 -> swap at timer 99; dropped_count_out = 1; frame_count_out = 0; fetch_rst_out high next cycle.
- buffer_ready_in stuck high after a swap, CLEAR_GUARD=4 -> Launch no earlier than 5 cycles after switch_out; pause_in high -> no Launch while timer swaps continue.
- rst_in pulsed mid-Render with pixel count 5 -> all counters 0; fetch_rst_out = 1; clear_out = 1 during reset; state WaitBuffer.
